mux2_share_arbiter: RTL and testbench



---
 rtl/mux2_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux2_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_share_arbiter.sv
// Round-robin arbiter sharing a 2:1 gated-mux datapath between requesters A and B, with a
// per-tenure beat cap. Define ARB_LOCK_EN to add a lock input that defers forced rotation.
module mux2_share_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             mux_sel,
    output logic             mux_en_n,
    output logic [WIDTH-1:0] y_out,
    output logic             y_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    localparam logic       LAST_A   = 1'b0;
    localparam logic       LAST_B   = 1'b1;
    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;

    logic       own_a, own_b;
    logic       beat;
    logic [3:0] cnt_inc;
    logic       at_hold;
    logic       hold_lock;
    logic       rotate_a, rotate_b;

    assign own_a = (state_q == OWN_A);
    assign own_b = (state_q == OWN_B);
    assign beat  = (own_a && req_a) || (own_b && req_b);

`ifdef ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // The cap is judged on the count including this cycle's beat, so rotation lands right
    // after the HOLD-th beat and the waiting side sees no extra beat from the owner.
    always_comb begin
        cnt_inc = cnt_q;
        if (beat && (cnt_q != HOLD_CNT)) begin
            cnt_inc = cnt_q + 4'd1;
        end
    end

    assign at_hold  = (cnt_inc == HOLD_CNT);
    assign rotate_a = own_a && req_a && at_hold && req_b && !hold_lock;
    assign rotate_b = own_b && req_b && at_hold && req_a && !hold_lock;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        last_d  = last_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || (last_q == LAST_B))) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end else if (rotate_a) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end else if (rotate_b) begin
                    state_d = OWN_A;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Owner change restarts the tenure; mux_sel only moves when a new owner takes over.
        if (state_d != state_q) begin
            cnt_d = 4'd0;
            if (state_q == OWN_A) begin
                last_d = LAST_A;
            end else if (state_q == OWN_B) begin
                last_d = LAST_B;
            end
            if (state_d == OWN_A) begin
                sel_d = 1'b0;
            end else if (state_d == OWN_B) begin
                sel_d = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = beat;
        y_d     = y_q;
        if (beat) begin
            y_d = sel_q ? data_b : data_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= LAST_B;
            sel_q   <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_a    = own_a;
    assign gnt_b    = own_b;
    assign mux_sel  = sel_q;
    assign mux_en_n = !(own_a || own_b);
    assign y_out    = y_q;
    assign y_valid  = valid_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed bench for mux2_share_arbiter: per-cycle grant checks plus a scoreboard of expected
// y_valid/y_out results. Lock steps are built only when ARB_LOCK_EN is defined.
module tb_mux2_share_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned HOLD  = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             req_a  = 1'b0;
    logic             req_b  = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic [WIDTH-1:0] data_b = '0;
`ifdef ARB_LOCK_EN
    logic             lock   = 1'b0;
`endif
    logic             gnt_a;
    logic             gnt_b;
    logic             mux_sel;
    logic             mux_en_n;
    logic [WIDTH-1:0] y_out;
    logic             y_valid;

    mux2_share_arbiter #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
`ifdef ARB_LOCK_EN
        .lock     (lock),
`endif
        .data_a   (data_a),
        .data_b   (data_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .mux_sel  (mux_sel),
        .mux_en_n (mux_en_n),
        .y_out    (y_out),
        .y_valid  (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t             sb[$];
    int               checks  = 0;
    int               errors  = 0;
    logic [WIDTH-1:0] last_y  = '0;
    logic             exp_sel = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".gnt_a"}, 8'(gnt_a), 8'h0);
        chk({tag, ".gnt_b"}, 8'(gnt_b), 8'h0);
        chk({tag, ".mux_sel"}, 8'(mux_sel), 8'h0);
        chk({tag, ".mux_en_n"}, 8'(mux_en_n), 8'h1);
        chk({tag, ".y_out"}, 8'(y_out), 8'h0);
        chk({tag, ".y_valid"}, 8'(y_valid), 8'h0);
    endtask

    // One clock: check the outputs of the previous edge, then drive this cycle's inputs.
    // ega/egb are the grants the arbiter must hold during the cycle being driven.
    task automatic step(input logic ra, input logic rb, input logic [WIDTH-1:0] da,
                        input logic [WIDTH-1:0] db, input logic ega, input logic egb);
        exp_t e;
        logic beat;
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("y_valid", 8'(y_valid), 8'(e.v));
            chk("y_out", 8'(y_out), 8'(e.d));
        end else begin
            chk("sb_empty", 8'(sb.size()), 8'h1);
        end
        if (ega) begin
            exp_sel = 1'b0;
        end else if (egb) begin
            exp_sel = 1'b1;
        end
        chk("gnt_a", 8'(gnt_a), 8'(ega));
        chk("gnt_b", 8'(gnt_b), 8'(egb));
        chk("gnt_excl", 8'(gnt_a & gnt_b), 8'h0);
        chk("mux_en_n", 8'(mux_en_n), 8'(!(ega || egb)));
        chk("mux_sel", 8'(mux_sel), 8'(exp_sel));
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
        beat   = (ega && ra) || (egb && rb);
        if (beat) begin
            last_y = egb ? db : da;
        end
        e.v = beat;
        e.d = last_y;
        sb.push_back(e);
    endtask

    // Asserted between edges so the outputs must clear without waiting for a clock.
    task automatic async_reset();
        exp_t e;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        sb.delete();
        last_y  = '0;
        exp_sel = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        e.v = 1'b0;
        e.d = '0;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;
        e.v = 1'b0;
        e.d = '0;
        sb.push_back(e);

        // Enter a tenure, then abort it with reset while req_a stays high.
        step(1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0);
        async_reset();

        // Single requester: no rotation past HOLD while B is idle.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 4'(3 + k), 4'h0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        async_reset();

        // Tie after reset goes to A, then 4-beat alternation with no idle bubble.
        step(1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 4'hA, 4'h5, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
        end

        // Early release by B after two beats hands straight over to A.
        step(1'b1, 1'b1, 4'hA, 4'hC, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'hA, 4'hD, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'hA, 4'hE, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 4'(1 + k), 4'h0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // A was served last, so a tie from idle goes to B.
        step(1'b1, 1'b1, 4'h7, 4'h6, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h7, 4'h6, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'h7, 4'h6, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h9, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h9, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
        // Lock keeps A past HOLD; dropping it rotates on the next edge.
        lock = 1'b1;
        step(1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0);
        end
        lock = 1'b0;
        step(1'b1, 1'b1, 4'hB, 4'h5, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'hB, 4'h6, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
`endif

        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
